// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Sklansky parallel-prefix adder with a valid/ready
// handshake on both sides. Level 0 forms per-bit p/g/x, levels 1..log2(WIDTH)
// build the prefix carries, and the last level also forms y/cout/ovf. Register
// stages are spread over those levels with the final register at the output.
// Optional feature macro: PREFIX_ADDER_SUB_EN adds the op_sub port (y = a - b).
module prefix_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PREFIX_ADDER_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  localparam int LOG   = $clog2(WIDTH);
  localparam int NL    = LOG + 1;
  localparam int BASE  = NL / STAGES;
  localparam int EXTRA = NL % STAGES;

  // Per-bit prefix state carried between levels; c is the carry-in, kept for bit 0's sum.
  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c;
  } pg_t;

  // Last logic level of stage s; the first EXTRA stages take one extra level.
  function automatic int stage_end(input int s);
    int n;
    n = (s + 1 < EXTRA) ? s + 1 : EXTRA;
    return (s + 1) * BASE + n - 1;
  endfunction

  // Stage that owns logic level l.
  function automatic int level_stage(input int l);
    int r;
    r = STAGES - 1;
    for (int s = STAGES - 1; s >= 0; s--) begin
      if (l <= stage_end(s)) r = s;
    end
    return r;
  endfunction

  // True when a register boundary follows logic level l.
  function automatic bit is_end(input int l);
    return l == stage_end(level_stage(l));
  endfunction

  // Level 0: propagate/generate/half-sum per bit. The carry-in is folded into
  // bit 0's generate so that every later G[i] is the group generate G[i:-1].
  function automatic pg_t incell(input logic [WIDTH-1:0] op_a,
                                 input logic [WIDTH-1:0] op_b,
                                 input logic             c_in);
    pg_t r;
    r.x    = op_a ^ op_b;
    r.p    = op_a | op_b;
    r.g    = op_a & op_b;
    r.g[0] = r.g[0] | (r.p[0] & c_in);
    r.c    = c_in;
    return r;
  endfunction

  // Sklansky level k: the upper half of each 2^k block combines with the last
  // bit of the lower half. Group propagates that reach bit 0 are never read
  // again, so those cells reduce to gray cells once unused p terms are trimmed.
  function automatic pg_t prefix_level(input pg_t d, input int k);
    pg_t r;
    int  blk;
    int  half;
    int  j;
    r    = d;
    blk  = 1 << k;
    half = blk >> 1;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i % blk) >= half) begin
        j      = (i / blk) * blk + half - 1;
        r.g[i] = d.g[i] | (d.p[i] & d.g[j]);
        r.p[i] = d.p[i] & d.p[j];
      end
    end
    return r;
  endfunction

  // Sum stage: y[i] = x[i] ^ G[i-1:-1]; ovf compares carries into and out of the MSB.
  function automatic logic [WIDTH+1:0] sum_out(input pg_t d);
    logic [WIDTH-1:0] carry;
    carry = {d.g[WIDTH-2:0], d.c};
    return {d.g[WIDTH-1] ^ d.g[WIDTH-2], d.g[WIDTH-1], d.x ^ carry};
  endfunction

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef PREFIX_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; the external carry-in is ignored.
  assign b_eff   = op_sub ? ~b : b;
  assign cin_eff = op_sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] vld_in;
  logic [STAGES-1:0] acc;
  logic [STAGES-1:0] load;

  // Stage s can accept when it or any stage after it is empty, or the output drains.
  always_comb begin
    logic chain;
    chain     = out_ready;
    vld_in[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      vld_in[s] = vld_p[s-1];
    end
    for (int s = STAGES - 1; s >= 0; s--) begin
      chain  = chain | ~vld_p[s];
      acc[s] = chain;
    end
    load = acc & vld_in;
  end

  assign in_ready  = acc[0];
  assign out_valid = vld_p[STAGES-1];

  // Stage valid bits advance whenever the stage accepts; in-flight beats are dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p <= (acc & vld_in) | (~acc & vld_p);
    end
  end

  pg_t lvl_in  [1:NL-1];
  pg_t lvl_out [NL];

  assign lvl_out[0] = incell(a, b_eff, cin_eff);

  for (genvar l = 1; l < NL; l++) begin : g_lvl
    assign lvl_out[l] = prefix_level(lvl_in[l], l);

    if (is_end(l - 1)) begin : g_reg
      pg_t pg_p;

      // Stage boundary after level l-1: payload loads only with a valid beat moving in.
      always_ff @(posedge clk) begin
        if (load[level_stage(l - 1)]) begin
          pg_p <= lvl_out[l-1];
        end
      end

      assign lvl_in[l] = pg_p;
    end else begin : g_wire
      assign lvl_in[l] = lvl_out[l-1];
    end
  end

  // Output stage boundary: result registers hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ovf, cout, y} <= '0;
    end else if (load[STAGES-1]) begin
      {ovf, cout, y} <= sum_out(lvl_out[NL-1]);
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed arithmetic vectors, latency, throughput,
// backpressure, reset behaviour and randomized traffic on three configurations
// (32/2, 8/4, 64/1) checked against an arithmetic reference model.
module tb_prefix_adder_pipe;

  localparam int W   = 32;
  localparam int S   = 2;
  localparam int S8  = 4;
  localparam int S64 = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  int            n_checks;
  int            n_fail;

  logic          in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0]  a, b, y;
`ifdef PREFIX_ADDER_SUB_EN
  logic          op_sub;
`endif

  logic          e8_in_valid, e8_in_ready, e8_cin, e8_out_valid, e8_out_ready, e8_cout, e8_ovf;
  logic [7:0]    e8_a, e8_b, e8_y;
  logic          e64_in_valid, e64_in_ready, e64_cin, e64_out_valid, e64_out_ready, e64_cout, e64_ovf;
  logic [63:0]   e64_a, e64_b, e64_y;

  always #5 clk = ~clk;

  prefix_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PREFIX_ADDER_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .cout(cout), .ovf(ovf)
  );

  prefix_adder_pipe #(.WIDTH(8), .STAGES(S8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(e8_in_valid), .in_ready(e8_in_ready),
    .a(e8_a), .b(e8_b), .cin(e8_cin),
`ifdef PREFIX_ADDER_SUB_EN
    .op_sub(1'b0),
`endif
    .out_valid(e8_out_valid), .out_ready(e8_out_ready), .y(e8_y), .cout(e8_cout), .ovf(e8_ovf)
  );

  prefix_adder_pipe #(.WIDTH(64), .STAGES(S64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(e64_in_valid), .in_ready(e64_in_ready),
    .a(e64_a), .b(e64_b), .cin(e64_cin),
`ifdef PREFIX_ADDER_SUB_EN
    .op_sub(1'b0),
`endif
    .out_valid(e64_out_valid), .out_ready(e64_out_ready), .y(e64_y), .cout(e64_cout), .ovf(e64_ovf)
  );

  // Reference: w-bit sum of x+z+c; returns {ovf, cout, y}. Overflow is the
  // two's-complement rule: equal operand signs, result sign differs.
  function automatic logic [129:0] ref_add(input int w, input logic [127:0] x,
                                           input logic [127:0] z, input logic c);
    logic [128:0] s;
    logic [127:0] mask, xm, zm, r;
    logic         co, ov;
    mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
    xm   = x & mask;
    zm   = z & mask;
    s    = {1'b0, xm} + {1'b0, zm} + 129'(c);
    r    = s[127:0] & mask;
    co   = s[w];
    ov   = (xm[w-1] == zm[w-1]) && (r[w-1] != xm[w-1]);
    return {ov, co, r};
  endfunction

  function automatic logic [127:0] rnd_op();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       r = '1;
      1:       r = '0;
      default: ;
    endcase
    return r;
  endfunction

  // Drives a single beat with out_ready=1 and reports the cycles until out_valid.
  task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         output int lat, output logic [W-1:0] ry, output logic rc,
                         output logic ro, output logic acc_ok);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1 acc_ok = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1; ry = '0; rc = 1'b0; ro = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk); #1;
      if (out_valid) begin
        lat = k; ry = y; rc = cout; ro = ovf;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h12345678; cin = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (y !== '0) begin n_fail++; $display("FAIL reset_y got=%h exp=0", y); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_add();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W-1:0] ey [3];
    logic         ec [3];
    logic         eo [3];
    int           lat;
    logic [W-1:0] ry;
    logic         rc, ro, ok;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'h00000001; vc[0] = 1'b0; ey[0] = 32'h00000000; ec[0] = 1'b1; eo[0] = 1'b0;
    va[1] = 32'h7FFFFFFF; vb[1] = 32'h00000001; vc[1] = 1'b0; ey[1] = 32'h80000000; ec[1] = 1'b0; eo[1] = 1'b1;
    va[2] = 32'h00000000; vb[2] = 32'h00000000; vc[2] = 1'b1; ey[2] = 32'h00000001; ec[2] = 1'b0; eo[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_one(va[i], vb[i], vc[i], lat, ry, rc, ro, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL add%0d_in_ready got=%b exp=1", i, ok); end
      n_checks++; if (lat != S) begin n_fail++; $display("FAIL add%0d_latency got=%0d exp=%0d", i, lat, S); end
      n_checks++; if (ry !== ey[i]) begin n_fail++; $display("FAIL add%0d_y got=%h exp=%h", i, ry, ey[i]); end
      n_checks++; if (rc !== ec[i]) begin n_fail++; $display("FAIL add%0d_cout got=%b exp=%b", i, rc, ec[i]); end
      n_checks++; if (ro !== eo[i]) begin n_fail++; $display("FAIL add%0d_ovf got=%b exp=%b", i, ro, eo[i]); end
    end
  endtask

`ifdef PREFIX_ADDER_SUB_EN
  task automatic test_sub();
    int           lat;
    logic [W-1:0] ry;
    logic         rc, ro, ok;
    op_sub = 1'b1;
    run_one(32'd5, 32'd7, 1'b0, lat, ry, rc, ro, ok);
    n_checks++; if (ry !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sub_5m7_y got=%h exp=fffffffe", ry); end
    n_checks++; if (rc !== 1'b0) begin n_fail++; $display("FAIL sub_5m7_cout got=%b exp=0", rc); end
    n_checks++; if (lat != S) begin n_fail++; $display("FAIL sub_latency got=%0d exp=%0d", lat, S); end
    run_one(32'd7, 32'd5, 1'b0, lat, ry, rc, ro, ok);
    n_checks++; if (ry !== 32'd2) begin n_fail++; $display("FAIL sub_7m5_y got=%h exp=2", ry); end
    n_checks++; if (rc !== 1'b1) begin n_fail++; $display("FAIL sub_7m5_cout got=%b exp=1", rc); end
    n_checks++; if (ro !== 1'b0) begin n_fail++; $display("FAIL sub_7m5_ovf got=%b exp=0", ro); end
    op_sub = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    logic [129:0] q[$];
    logic [129:0] e;
    int sent, got, first_cyc, last_cyc;
    sent = 0; got = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (sent < 16);
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      #1;
      if (in_valid) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
      end
      if (out_valid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious cyc=%0d got out_valid=1 exp=0", cyc);
        end else begin
          e = q.pop_front();
          if ({ovf, cout, y} !== {e[129], e[128], e[31:0]}) begin
            n_fail++; $display("FAIL b2b_result cyc=%0d got=%b_%b_%h exp=%b_%b_%h", cyc, ovf, cout, y, e[129], e[128], e[31:0]);
          end
        end
        got++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_add(W, {96'b0, a}, {96'b0, b}, cin));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 16 || (last_cyc - first_cyc) != 15) begin
      n_fail++; $display("FAIL b2b_throughput got=%0d beats over %0d cycles exp=16 over 16", got, last_cyc - first_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [129:0] q[$];
    logic [129:0] e;
    logic         exp_rdy, held, need_new;
    logic [W+1:0] held_val;
    int           sent, got, first_block;
    sent = 0; got = 0; first_block = -1; held = 1'b0; need_new = 1'b1; held_val = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 8);
      if (need_new) begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); need_new = 1'b0;
      end
      #1;
      exp_rdy = !(q.size() == S && !out_ready);
      n_checks++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
      if (in_valid && !in_ready && first_block < 0) first_block = sent;
      if (held) begin
        n_checks++;
        if (out_valid !== 1'b1 || {ovf, cout, y} !== held_val) begin
          n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, {ovf, cout, y}, held_val);
        end
      end
      held     = out_valid && !out_ready;
      held_val = {ovf, cout, y};
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_spurious cyc=%0d got out_valid=1 exp=0", cyc);
        end else begin
          e = q.pop_front();
          if ({ovf, cout, y} !== {e[129], e[128], e[31:0]}) begin
            n_fail++; $display("FAIL bp_result cyc=%0d got=%b_%b_%h exp=%b_%b_%h", cyc, ovf, cout, y, e[129], e[128], e[31:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_add(W, {96'b0, a}, {96'b0, b}, cin));
        sent++; need_new = 1'b1;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL bp_delivered got=%0d exp=8", got); end
    n_checks++; if (first_block != S) begin n_fail++; $display("FAIL bp_accepts_before_stall got=%0d exp=%0d", first_block, S); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h80000000; cin = 1'b0;
    repeat (S + 2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || {ovf, cout, y} !== {1'b1, 1'b1, 32'h7FFFFFFF}) begin
      n_fail++; $display("FAIL midrst_pre got=%b/%b_%b_%h exp=1/1_1_7fffffff", out_valid, ovf, cout, y);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    n_checks++; if ({ovf, cout, y} !== '0) begin n_fail++; $display("FAIL midrst_outputs got=%b_%b_%h exp=0", ovf, cout, y); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < S + 3; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL midrst_flushed k=%0d got out_valid=%b in_ready=%b exp 0/1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random(input int cycles);
    logic [129:0] q32[$], q8[$], q64[$];
    logic [129:0] e;
    logic [127:0] r1, r2;
    logic         p32, p8, p64, drain, exp_rdy;
    p32 = 1'b0; p8 = 1'b0; p64 = 1'b0;
    for (int cyc = 0; cyc < cycles + 40; cyc++) begin
      @(negedge clk);
      drain = (cyc >= cycles);
      if (!p32) begin
        in_valid = !drain && ($urandom_range(0, 99) < 70);
        r1 = rnd_op(); r2 = rnd_op();
        a = r1[31:0]; b = r2[31:0]; cin = 1'($urandom_range(0, 1));
`ifdef PREFIX_ADDER_SUB_EN
        op_sub = 1'($urandom_range(0, 1));
`endif
      end
      if (!p8) begin
        e8_in_valid = !drain && ($urandom_range(0, 99) < 70);
        r1 = rnd_op(); r2 = rnd_op();
        e8_a = r1[7:0]; e8_b = r2[7:0]; e8_cin = 1'($urandom_range(0, 1));
      end
      if (!p64) begin
        e64_in_valid = !drain && ($urandom_range(0, 99) < 70);
        r1 = rnd_op(); r2 = rnd_op();
        e64_a = r1[63:0]; e64_b = r2[63:0]; e64_cin = 1'($urandom_range(0, 1));
      end
      out_ready     = drain || ($urandom_range(0, 99) < 70);
      e8_out_ready  = drain || ($urandom_range(0, 99) < 70);
      e64_out_ready = drain || ($urandom_range(0, 99) < 70);
      #1;
      // 32-bit, 2 stages
      exp_rdy = !(q32.size() == S && !out_ready);
      n_checks++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd32_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q32.size() == 0) begin
          n_fail++; $display("FAIL rnd32_spurious cyc=%0d got out_valid=1 exp=0", cyc);
        end else begin
          e = q32.pop_front();
          if ({ovf, cout, y} !== {e[129], e[128], e[31:0]}) begin
            n_fail++; $display("FAIL rnd32_result cyc=%0d got=%b_%b_%h exp=%b_%b_%h", cyc, ovf, cout, y, e[129], e[128], e[31:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
`ifdef PREFIX_ADDER_SUB_EN
        if (op_sub) q32.push_back(ref_add(W, {96'b0, a}, {96'b0, ~b}, 1'b1));
        else        q32.push_back(ref_add(W, {96'b0, a}, {96'b0, b}, cin));
`else
        q32.push_back(ref_add(W, {96'b0, a}, {96'b0, b}, cin));
`endif
      end
      p32 = in_valid && !in_ready;
      // 8-bit, 4 stages
      exp_rdy = !(q8.size() == S8 && !e8_out_ready);
      n_checks++;
      if (e8_in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd8_in_ready cyc=%0d got=%b exp=%b", cyc, e8_in_ready, exp_rdy); end
      if (e8_out_valid && e8_out_ready) begin
        n_checks++;
        if (q8.size() == 0) begin
          n_fail++; $display("FAIL rnd8_spurious cyc=%0d got out_valid=1 exp=0", cyc);
        end else begin
          e = q8.pop_front();
          if ({e8_ovf, e8_cout, e8_y} !== {e[129], e[128], e[7:0]}) begin
            n_fail++; $display("FAIL rnd8_result cyc=%0d got=%b_%b_%h exp=%b_%b_%h", cyc, e8_ovf, e8_cout, e8_y, e[129], e[128], e[7:0]);
          end
        end
      end
      if (e8_in_valid && e8_in_ready) q8.push_back(ref_add(8, {120'b0, e8_a}, {120'b0, e8_b}, e8_cin));
      p8 = e8_in_valid && !e8_in_ready;
      // 64-bit, 1 stage
      exp_rdy = !(q64.size() == S64 && !e64_out_ready);
      n_checks++;
      if (e64_in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd64_in_ready cyc=%0d got=%b exp=%b", cyc, e64_in_ready, exp_rdy); end
      if (e64_out_valid && e64_out_ready) begin
        n_checks++;
        if (q64.size() == 0) begin
          n_fail++; $display("FAIL rnd64_spurious cyc=%0d got out_valid=1 exp=0", cyc);
        end else begin
          e = q64.pop_front();
          if ({e64_ovf, e64_cout, e64_y} !== {e[129], e[128], e[63:0]}) begin
            n_fail++; $display("FAIL rnd64_result cyc=%0d got=%b_%b_%h exp=%b_%b_%h", cyc, e64_ovf, e64_cout, e64_y, e[129], e[128], e[63:0]);
          end
        end
      end
      if (e64_in_valid && e64_in_ready) q64.push_back(ref_add(64, {64'b0, e64_a}, {64'b0, e64_b}, e64_cin));
      p64 = e64_in_valid && !e64_in_ready;
    end
    in_valid = 1'b0; e8_in_valid = 1'b0; e64_in_valid = 1'b0;
    n_checks++;
    if (q32.size() != 0 || q8.size() != 0 || q64.size() != 0) begin
      n_fail++; $display("FAIL rnd_undelivered got=%0d/%0d/%0d exp=0/0/0", q32.size(), q8.size(), q64.size());
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
`ifdef PREFIX_ADDER_SUB_EN
    op_sub = 1'b0;
`endif
    e8_in_valid = 1'b0; e8_a = '0; e8_b = '0; e8_cin = 1'b0; e8_out_ready = 1'b1;
    e64_in_valid = 1'b0; e64_a = '0; e64_b = '0; e64_cin = 1'b0; e64_out_ready = 1'b1;
    test_reset();
    test_add();
`ifdef PREFIX_ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random(6000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
